// File: rtl/transfer_to_host_arbiter.sv
// transfer_to_host_arbiter
// Round-robin arbiter that shares one active_transfer "to host" channel
// among NUM_REQ requesters. The winner's address/data byte is captured and
// start_transfer is held for a fixed window. The FSM then follows
// transfer_busy high and low. Each transfer ends with one ack pulse and
// either a done pulse or an error pulse for the owning requester.
// Every output comes straight from a flop.

module transfer_to_host_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 8,
    parameter int START_HOLD   = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                      uc_clk,
    input  logic                      uc_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_error,
    output logic                      start_transfer,
    output logic [ADDR_W-1:0]         uc_addr,
    output logic [DATA_W-1:0]         transfer_to_host,
    input  logic                      transfer_busy,
    output logic                      arb_busy
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam int TO_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_t;

    // Per-requester view of the flat address/data buses (slot i = bits [i*W +: W])
    logic [NUM_REQ-1:0][ADDR_W-1:0] slot_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] slot_data;

    assign slot_addr = req_addr;
    assign slot_data = req_data;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                arb_busy_q, arb_busy_d;

    logic                arb_found;
    logic [PTR_W-1:0]    arb_win;
    logic [PTR_W-1:0]    scan;

    // Round-robin search: first valid requester at or after rr_q, wrapping
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = PTR_W'((int'(rr_q) + i) % NUM_REQ);
            if (!arb_found && req_valid[scan]) begin
                arb_found = 1'b1;
                arb_win   = scan;
            end
        end
    end

    // Next-state and next-output logic for the transfer FSM
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        to_d       = to_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        data_d     = data_q;
        start_d    = 1'b0;
        ack_d      = '0;
        done_d     = '0;
        err_d      = '0;

        case (state_q)
            S_IDLE: begin
                // Requests are only looked at here; the winner's slot is
                // latched so the requester may change or drop it after ack.
                if (arb_found) begin
                    state_d       = S_START;
                    hold_d        = '0;
                    grant_d       = arb_win;
                    rr_d          = PTR_W'((int'(arb_win) + 1) % NUM_REQ);
                    addr_d        = slot_addr[arb_win];
                    data_d        = slot_data[arb_win];
                    start_d       = 1'b1;
                    ack_d[arb_win] = 1'b1;
                end
            end
            S_START: begin
                // hold_q counts START cycles already spent (0..START_HOLD-1)
                if (hold_q == HOLD_W'(START_HOLD - 1)) begin
                    state_d = S_WAIT_HI;
                    to_d    = '0;
                end else begin
                    hold_d  = hold_q + 1'b1;
                    start_d = 1'b1;
                end
            end
            S_WAIT_HI: begin
                // Busy is tested first so a rise on the last allowed cycle
                // still counts as success.
                if (transfer_busy) begin
                    state_d = S_WAIT_LO;
                end else if (to_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                // No timeout here: the host side may stall indefinitely
                if (!transfer_busy) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = S_GAP;
                end
            end
            S_GAP: begin
                // Guarantees start_transfer is low for at least one cycle
                // between back-to-back transfers.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        arb_busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; async reset drops everything immediately
    always_ff @(posedge uc_clk or negedge uc_reset) begin
        if (!uc_reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            to_q       <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            to_q       <= to_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            start_q    <= start_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            arb_busy_q <= arb_busy_d;
        end
    end

    assign req_ack          = ack_q;
    assign req_done         = done_q;
    assign req_error        = err_q;
    assign start_transfer   = start_q;
    assign uc_addr          = addr_q;
    assign transfer_to_host = data_q;
    assign arb_busy         = arb_busy_q;

endmodule
